// File: rtl/nio2_dbg_pkg.sv
// Shared constants and helpers for the Nios II debug command path.
package nio2_dbg_pkg;

   localparam int IR_OCIMEM    = 0;
   localparam int IR_TRACECTRL = 1;
   localparam int IR_BREAK     = 2;

   // Occupancy counter width: must be able to hold DEPTH itself.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/nio2_dbg_cmd_fifo.sv
// Generic first-word-fall-through synchronous FIFO; head is visible while not empty.
module nio2_dbg_cmd_fifo
   import nio2_dbg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              din,
   output logic [WIDTH-1:0]              dout,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LW'(DEPTH));
   // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if the head leaves.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign level   = count;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // NOTE: storage is deliberately not reset; the gated dout and the reset pointers make its contents irrelevant.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/nio2_sys_cpu_debug_cmd_queue.sv
// Sysclk-side debug command front end: strobe sync, scan capture into a FIFO, one-hot action decode.
module nio2_sys_cpu_debug_cmd_queue
   import nio2_dbg_pkg::*;
#(
   parameter int IR_W        = 2,
   parameter int DATA_W      = 38,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ACT_BIT     = 35
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          vs_uir,
   input  logic                          vs_udr,
   input  logic [IR_W-1:0]               ir_in,
   input  logic [DATA_W-1:0]             sr,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [IR_W-1:0]               cmd_ir,
   output logic [DATA_W-1:0]             cmd_data,
   output logic [DATA_W-1:0]             jdo,
   output logic [2**IR_W-1:0]            take_action,
   output logic [2**IR_W-1:0]            take_no_action,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          overflow,
   input  logic                          ovf_clr
);

   localparam int N_ACT = 2**IR_W;

   logic [SYNC_STAGES-1:0]   uir_sync;
   logic [SYNC_STAGES-1:0]   udr_sync;
   logic [SYNC_STAGES-1:0]   vld_sync;
   logic                     uir_prev;
   logic                     udr_prev;
   logic                     uir_armed;
   logic                     udr_armed;
   logic                     uir_edge;
   logic                     udr_edge;
   logic [IR_W-1:0]          ir_q;
   logic                     pop;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [IR_W+DATA_W-1:0]   head;
   logic [N_ACT-1:0]         onehot;

   assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_prev & uir_armed;
   assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_prev & udr_armed;

   // vld_sync marks when the last sync stage holds a real sample rather than its reset zero,
   // so a strobe held high through reset release never looks like a low-to-high transition.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uir_sync  <= '0;
         udr_sync  <= '0;
         vld_sync  <= '0;
         uir_prev  <= 1'b0;
         udr_prev  <= 1'b0;
         uir_armed <= 1'b0;
         udr_armed <= 1'b0;
         ir_q      <= '0;
         overflow  <= 1'b0;
      end else begin
         uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
         uir_prev  <= uir_sync[SYNC_STAGES-1];
         udr_prev  <= udr_sync[SYNC_STAGES-1];
         uir_armed <= uir_armed | (vld_sync[SYNC_STAGES-1] & ~uir_sync[SYNC_STAGES-1]);
         udr_armed <= udr_armed | (vld_sync[SYNC_STAGES-1] & ~udr_sync[SYNC_STAGES-1]);
         if (uir_edge) ir_q <= ir_in;
         overflow  <= (udr_edge & fifo_full & ~pop) | (overflow & ~ovf_clr);
      end
   end

   nio2_dbg_cmd_fifo #(
      .WIDTH (IR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (udr_edge),
      .pop     (cmd_ready),
      .din     ({ir_q, sr}),
      .dout    (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign cmd_valid          = ~fifo_empty;
   assign {cmd_ir, cmd_data} = head;
   assign pop                = cmd_valid & cmd_ready;

   always_comb begin
      onehot         = '0;
      onehot[cmd_ir] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jdo            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
      end else begin
         take_action    <= (pop &  cmd_data[ACT_BIT]) ? onehot : '0;
         take_no_action <= (pop & ~cmd_data[ACT_BIT]) ? onehot : '0;
         if (pop) jdo <= cmd_data;
      end
   end

endmodule

// File: tb/tb_nio2_sys_cpu_debug_cmd_queue.sv
// Directed bench for the debug command queue: table-driven single commands plus FIFO/reset corner sequences.
module tb_nio2_sys_cpu_debug_cmd_queue;
   import nio2_dbg_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vs_uir;
   logic        vs_udr;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_ir;
   logic [37:0] cmd_data;
   logic [37:0] jdo;
   logic [3:0]  take_action;
   logic [3:0]  take_no_action;
   logic [2:0]  level;
   logic        overflow;
   logic        ovf_clr;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] data;
      logic [3:0]  exp_act;
      logic [3:0]  exp_noact;
   } vec_t;

   vec_t vecs [4];

   always #5 clk = ~clk;

   nio2_sys_cpu_debug_cmd_queue dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .vs_uir         (vs_uir),
      .vs_udr         (vs_udr),
      .ir_in          (ir_in),
      .sr             (sr),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_ir         (cmd_ir),
      .cmd_data       (cmd_data),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .level          (level),
      .overflow       (overflow),
      .ovf_clr        (ovf_clr)
   );

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic pulse_uir(input logic [1:0] ir);
      ir_in  = ir;
      vs_uir = 1'b1;
      repeat (5) @(negedge clk);
      vs_uir = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic pulse_udr(input logic [37:0] data);
      sr     = data;
      vs_udr = 1'b1;
      repeat (5) @(negedge clk);
      vs_udr = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;

      vecs[0] = '{ir: 2'(IR_BREAK),     data: 38'h08_0000_00A5, exp_act: 4'b0100, exp_noact: 4'b0000};
      vecs[1] = '{ir: 2'(IR_OCIMEM),    data: 38'h00_0000_0012, exp_act: 4'b0000, exp_noact: 4'b0001};
      vecs[2] = '{ir: 2'(IR_TRACECTRL), data: 38'h3F_FFFF_FFFF, exp_act: 4'b0010, exp_noact: 4'b0000};
      vecs[3] = '{ir: 2'd3,             data: 38'h37_FFFF_FFFF, exp_act: 4'b0000, exp_noact: 4'b1000};

      reset_n   = 1'b0;
      vs_uir    = 1'b0;
      vs_udr    = 1'b0;
      ir_in     = '0;
      sr        = '0;
      cmd_ready = 1'b0;
      ovf_clr   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_cmd_ir", 64'(cmd_ir), 64'd0);
      check("rst_cmd_data", 64'(cmd_data), 64'd0);
      check("rst_jdo", 64'(jdo), 64'd0);
      check("rst_pulses", 64'({take_action, take_no_action}), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);

      // Single commands: uir, then udr with consumer ready; check latency, pulse and jdo.
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pulse_uir(vecs[i].ir);
         sr     = vecs[i].data;
         vs_udr = 1'b1;
         repeat (2) @(negedge clk);
         check("valid_edge2", 64'(cmd_valid), 64'd0);
         @(negedge clk);
         check("valid_edge3", 64'(cmd_valid), 64'd1);
         lat = 0;
         for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if ((take_action | take_no_action) != 4'd0) lat = k;
         end
         check("pulse_latency", 64'(lat), 64'd1);
         check("take_action", 64'(take_action), 64'(vecs[i].exp_act));
         check("take_no_action", 64'(take_no_action), 64'(vecs[i].exp_noact));
         check("jdo", 64'(jdo), 64'(vecs[i].data));
         @(negedge clk);
         check("pulse_one_cycle", 64'({take_action, take_no_action}), 64'd0);
         vs_udr = 1'b0;
         repeat (5) @(negedge clk);
      end
      cmd_ready = 1'b0;

      // Fill and overflow.
      for (int i = 1; i <= 4; i++) pulse_udr(38'(i));
      check("fill_level", 64'(level), 64'd4);
      check("fill_no_ovf", 64'(overflow), 64'd0);
      pulse_udr(38'd5);
      check("ovf_level", 64'(level), 64'd4);
      check("ovf_set", 64'(overflow), 64'd1);
      cmd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_valid", 64'(cmd_valid), 64'd1);
         check("drain_data", 64'(cmd_data), 64'(i));
         @(negedge clk);
      end
      cmd_ready = 1'b0;
      check("drain_level", 64'(level), 64'd0);
      check("drain_jdo", 64'(jdo), 64'd4);
      check("ovf_sticky", 64'(overflow), 64'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("ovf_clr", 64'(overflow), 64'd0);

      // Full with push and pop on the same edge.
      for (int i = 11; i <= 14; i++) pulse_udr(38'(i));
      check("full2_level", 64'(level), 64'd4);
      sr     = 38'd15;
      vs_udr = 1'b1;
      repeat (2) @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check("pp_level", 64'(level), 64'd4);
      check("pp_no_ovf", 64'(overflow), 64'd0);
      check("pp_jdo", 64'(jdo), 64'd11);
      repeat (3) @(negedge clk);
      vs_udr = 1'b0;
      repeat (5) @(negedge clk);
      cmd_ready = 1'b1;
      for (int i = 12; i <= 15; i++) begin
         check("pp_drain", 64'(cmd_data), 64'(i));
         @(negedge clk);
      end
      cmd_ready = 1'b0;
      check("pp_empty", 64'(cmd_valid), 64'd0);

      // Reset while a udr strobe is being synchronised, released with the strobe still high.
      sr     = 38'h2A;
      vs_udr = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_strobe_level", 64'(level), 64'd0);
      check("rst_strobe_valid", 64'(cmd_valid), 64'd0);
      vs_udr = 1'b0;
      repeat (5) @(negedge clk);
      pulse_udr(38'h55);
      check("post_rst_level", 64'(level), 64'd1);
      check("post_rst_data", 64'(cmd_data), 64'h55);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check("post_rst_jdo", 64'(jdo), 64'h55);

      // Simultaneous uir/udr edges: push takes the previous ir_q.
      pulse_uir(2'd1);
      ir_in  = 2'd3;
      sr     = 38'h77;
      vs_uir = 1'b1;
      vs_udr = 1'b1;
      repeat (5) @(negedge clk);
      vs_uir = 1'b0;
      vs_udr = 1'b0;
      repeat (5) @(negedge clk);
      check("simul_level", 64'(level), 64'd1);
      check("simul_ir_old", 64'(cmd_ir), 64'd1);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check("simul_noact", 64'(take_no_action), 64'b0010);
      pulse_udr(38'h88);
      check("simul_ir_new", 64'(cmd_ir), 64'd3);
      check("simul_data_new", 64'(cmd_data), 64'h88);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
